// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared constants, voice record and transposition helpers
package tone_pkg;

  localparam int F_S = 48000;

  // round(f * 2^32 / F_S) for C4..B4
  localparam logic [31:0] KEY_INC [12] = '{
    32'd23409859, 32'd24801882, 32'd26276679, 32'd27839171,
    32'd29494575, 32'd31248413, 32'd33106541, 32'd35075158,
    32'd37160835, 32'd39370534, 32'd41711627, 32'd44191930
  };

  localparam logic signed [2:0] OCT_MIN = -3'sd2;
  localparam logic signed [2:0] OCT_MAX = 3'sd2;

  typedef struct packed {
    logic        active;
    logic [3:0]  key;
    logic [31:0] cur;
    logic [31:0] tgt;
  } voice_t;

  function automatic logic signed [2:0] legal_octave(input logic signed [2:0] s);
    return (s < OCT_MIN || s > OCT_MAX) ? 3'sd0 : s;
  endfunction

  function automatic logic [33:0] transpose(input logic [3:0] key, input logic signed [2:0] s);
    logic [31:0] base;
    base = (key < 4'd12) ? KEY_INC[key] : 32'd0;
    case (legal_octave(s))
      3'sd1:   return {1'b0, base, 1'b0};
      3'sd2:   return {base, 2'b00};
      -3'sd1:  return {3'b000, base[31:1]};
      -3'sd2:  return {4'b0000, base[31:2]};
      default: return {2'b00, base};
    endcase
  endfunction

endpackage

// File: rtl/tone_voice_allocator_if.sv
// rtl/tone_voice_allocator_if.sv - keyboard-side inputs and NCO-bank outputs of the allocator
interface tone_voice_allocator_if #(
  parameter int NUM_KEYS   = 12,
  parameter int NUM_VOICES = 4,
  parameter int INC_W      = 32
);
  logic                        sample_tick;
  logic [NUM_KEYS-1:0]         keys;
  logic [2:0]                  octave_shift;
  logic                        glide_en;
  logic [NUM_VOICES*INC_W-1:0] nco_increment_value;
  logic [NUM_VOICES-1:0]       nco_mute;
  logic [NUM_VOICES*4-1:0]     voice_key;
  logic                        test_LED_R;

  modport master (
    output sample_tick, keys, octave_shift, glide_en,
    input  nco_increment_value, nco_mute, voice_key, test_LED_R
  );

  modport slave (
    input  sample_tick, keys, octave_shift, glide_en,
    output nco_increment_value, nco_mute, voice_key, test_LED_R
  );
endinterface

// File: rtl/nco_glide.sv
// rtl/nco_glide.sv - one voice's current increment with jump or exponential glide towards target
module nco_glide #(
  parameter int INC_W       = 32,
  parameter int GLIDE_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_tick,
  input  logic             glide_en,
  input  logic             active,
  input  logic [INC_W-1:0] tgt,
  output logic [INC_W-1:0] cur
);

  logic signed [INC_W:0] diff;
  logic signed [INC_W:0] step;
  logic [INC_W:0]        mag;
  logic                  snap;
  logic [INC_W-1:0]      cur_next;

  always_comb begin
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    step = diff >>> GLIDE_SHIFT;
    mag  = diff[INC_W] ? (INC_W+1)'(-diff) : (INC_W+1)'(diff);
    // small residues would never close under the arithmetic shift, and 0 means "never sounded"
    snap = (mag < ((INC_W+1)'(1) << GLIDE_SHIFT)) || (cur == '0);
    cur_next = cur;
    if (active) begin
      if (!glide_en)
        cur_next = tgt;
      else if (sample_tick)
        cur_next = snap ? tgt : INC_W'($signed({1'b0, cur}) + step);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      cur <= '0;
    else
      cur <= cur_next;
  end

endmodule

// File: rtl/tone_voice_allocator.sv
// rtl/tone_voice_allocator.sv - scans the key bank and assigns pressed keys to NCO voices
module tone_voice_allocator
  import tone_pkg::*;
#(
  parameter int NUM_KEYS    = 12,
  parameter int NUM_VOICES  = 4,
  parameter int INC_W       = 32,
  parameter int GLIDE_SHIFT = 4
) (
  input logic                   clk,
  input logic                   rst,
  tone_voice_allocator_if.slave bus
);

  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [NUM_KEYS-1:0]   key_q, pending, rel_q;
  logic [NUM_KEYS-1:0]   rise, fall, cand, svc_onehot, pending_next;
  logic [15:0]           rel_wide;
  logic [VW-1:0]         steal_ptr, steal_ptr_next, free_idx, alloc_idx;
  logic [NUM_VOICES-1:0] mute, mute_next;
  logic [3:0]            vkey      [NUM_VOICES];
  logic [3:0]            vkey_next [NUM_VOICES];
  logic [3:0]            svc_key;
  logic                  svc_valid, free_valid, led_q;
  logic [INC_W-1:0]      cur_v     [NUM_VOICES];
  voice_t                view      [NUM_VOICES];

  always_comb begin
    rise           = bus.keys & ~key_q;
    fall           = key_q & ~bus.keys;
    rel_wide       = 16'(rel_q);
    mute_next      = mute;
    vkey_next      = vkey;
    steal_ptr_next = steal_ptr;

    // releases land before allocation so a freed voice can be reused this cycle
    for (int v = 0; v < NUM_VOICES; v++)
      if (!mute[v] && rel_wide[vkey[v]])
        mute_next[v] = 1'b1;

    cand      = pending & ~fall;
    svc_valid = 1'b0;
    svc_key   = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--)
      if (cand[k]) begin
        svc_valid = 1'b1;
        svc_key   = 4'(k);
      end

    free_valid = 1'b0;
    free_idx   = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--)
      if (mute_next[v]) begin
        free_valid = 1'b1;
        free_idx   = VW'(v);
      end
    alloc_idx = free_valid ? free_idx : steal_ptr;

    svc_onehot = '0;
    if (svc_valid) begin
      svc_onehot           = NUM_KEYS'(1) << svc_key;
      vkey_next[alloc_idx] = svc_key;
      mute_next[alloc_idx] = 1'b0;
      if (!free_valid)
        steal_ptr_next = (steal_ptr == VW'(NUM_VOICES - 1)) ? '0 : steal_ptr + 1'b1;
    end
    pending_next = ((pending & ~svc_onehot) | rise) & ~fall;
  end

  // targets follow the next-state key so a fresh allocation is in tune on the same edge
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      view[v].active = ~mute_next[v];
      view[v].key    = vkey_next[v];
      view[v].tgt    = 32'(INC_W'(transpose(view[v].key, $signed(bus.octave_shift)) >> (32 - INC_W)));
      view[v].cur    = 32'(cur_v[v]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q     <= '0;
      pending   <= '0;
      rel_q     <= '0;
      steal_ptr <= '0;
      mute      <= '1;
      led_q     <= 1'b1;
      for (int v = 0; v < NUM_VOICES; v++)
        vkey[v] <= '0;
    end else begin
      key_q     <= bus.keys;
      pending   <= pending_next;
      rel_q     <= fall;
      steal_ptr <= steal_ptr_next;
      mute      <= mute_next;
      led_q     <= &mute_next;
      vkey      <= vkey_next;
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    nco_glide #(
      .INC_W      (INC_W),
      .GLIDE_SHIFT(GLIDE_SHIFT)
    ) u_glide (
      .clk        (clk),
      .rst        (rst),
      .sample_tick(bus.sample_tick),
      .glide_en   (bus.glide_en),
      .active     (view[g].active),
      .tgt        (view[g].tgt[INC_W-1:0]),
      .cur        (cur_v[g])
    );

    assign bus.nco_increment_value[g*INC_W +: INC_W] = view[g].cur[INC_W-1:0];
    assign bus.voice_key[g*4 +: 4]                   = vkey[g];
  end

  assign bus.nco_mute   = mute;
  assign bus.test_LED_R = led_q;

endmodule

// File: tb/tb_tone_voice_allocator.sv
// tb/tb_tone_voice_allocator.sv - directed checks of allocation, stealing, transposition, glide and reset
module tb_tone_voice_allocator;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  tone_voice_allocator_if #(.NUM_KEYS(12), .NUM_VOICES(4), .INC_W(32)) bus ();

  tone_voice_allocator #(
    .NUM_KEYS   (12),
    .NUM_VOICES (4),
    .INC_W      (32),
    .GLIDE_SHIFT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] inc(input int v);
    return 64'(bus.nco_increment_value[v*32 +: 32]);
  endfunction

  function automatic logic [63:0] vk(input int v);
    return 64'(bus.voice_key[v*4 +: 4]);
  endfunction

  function automatic logic [63:0] mutes();
    return 64'(bus.nco_mute);
  endfunction

  logic [63:0] exp_inc, prev, diff;
  logic        done;

  initial begin
    rst              = 1'b1;
    bus.keys         = '0;
    bus.octave_shift = 3'd0;
    bus.glide_en     = 1'b0;
    bus.sample_tick  = 1'b0;
    step(2);
    check("rst_mute", mutes(), 64'hF);
    check("rst_inc_or", 64'(|bus.nco_increment_value), 64'd0);
    check("rst_voice_key", 64'(bus.voice_key), 64'd0);
    check("rst_led", 64'(bus.test_LED_R), 64'd1);
    check("rst_steal_ptr", 64'(dut.steal_ptr), 64'd0);

    // single press and release of A4
    rst = 1'b0;
    bus.keys = 12'h200;
    step(1);
    check("press_latency", mutes(), 64'hF);
    step(1);
    check("a4_mute", mutes(), 64'hE);
    check("a4_inc", inc(0), 64'd39370534);
    check("a4_key", vk(0), 64'd9);
    check("a4_led", 64'(bus.test_LED_R), 64'd0);
    bus.keys = 12'h000;
    step(1);
    check("release_latency", mutes(), 64'hE);
    step(1);
    check("a4_release_mute", mutes(), 64'hF);
    check("a4_release_hold", inc(0), 64'd39370534);
    check("a4_release_led", 64'(bus.test_LED_R), 64'd1);

    // chord C E G pressed together
    bus.keys = 12'h091;
    step(2);
    check("chord_v0_mute", mutes(), 64'hE);
    check("chord_v0_key", vk(0), 64'd0);
    check("chord_c4_inc", inc(0), 64'd23409859);
    step(1);
    check("chord_v1_mute", mutes(), 64'hC);
    check("chord_v1_key", vk(1), 64'd4);
    step(1);
    check("chord_v2_mute", mutes(), 64'h8);
    check("chord_keys", 64'(bus.voice_key), 64'h0740);

    // fill the last voice, then steal
    bus.keys = 12'h291;
    step(2);
    check("fill_mute", mutes(), 64'h0);
    check("fill_inc3", inc(3), 64'd39370534);
    bus.keys = 12'hA91;
    step(2);
    check("steal_key", vk(0), 64'd11);
    check("steal_inc", inc(0), 64'd44191930);
    check("steal_mute", mutes(), 64'h0);
    check("steal_ptr", 64'(dut.steal_ptr), 64'd1);
    bus.keys = 12'hA90;
    step(2);
    check("stolen_release_mute", mutes(), 64'h0);
    check("stolen_release_keys", 64'(bus.voice_key), 64'h974B);

    // live transposition of held voices
    bus.octave_shift = 3'd1;
    step(1);
    check("oct_p1_inc3", inc(3), 64'd78741068);
    check("oct_p1_mute", mutes(), 64'h0);
    bus.octave_shift = 3'b110;
    step(1);
    check("oct_m2_inc3", inc(3), 64'd9842633);
    check("oct_m2_inc0", inc(0), 64'd11047982);
    check("oct_m2_mute", mutes(), 64'h0);
    bus.octave_shift = 3'd3;
    step(1);
    check("oct_illegal_inc3", inc(3), 64'd39370534);
    check("oct_illegal_inc0", inc(0), 64'd44191930);
    bus.octave_shift = 3'd0;

    // glide from C4 to B4 on one voice
    bus.keys = 12'h000;
    step(2);
    check("all_released", mutes(), 64'hF);
    bus.keys = 12'h001;
    step(2);
    check("glide_start_inc", inc(0), 64'd23409859);
    bus.glide_en = 1'b1;
    bus.keys = 12'h800;
    step(2);
    check("glide_realloc_mute", mutes(), 64'hE);
    check("glide_realloc_key", vk(0), 64'd11);
    check("glide_hold_no_tick", inc(0), 64'd23409859);
    exp_inc = 64'd23409859;
    prev    = exp_inc;
    done    = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      bus.sample_tick = 1'b1;
      step(1);
      bus.sample_tick = 1'b0;
      diff = 64'd44191930 - exp_inc;
      if (diff < 64'd16)
        exp_inc = 64'd44191930;
      else
        exp_inc = exp_inc + (diff >> 4);
      if (i == 0)
        check("glide_first_step", inc(0), 64'd24708738);
      check("glide_step", inc(0), exp_inc);
      check("glide_bounded", 64'(inc(0) >= prev && inc(0) <= 64'd44191930), 64'd1);
      prev = inc(0);
      done = (inc(0) == 64'd44191930);
      step(1);
    end
    check("glide_converged", 64'(done), 64'd1);
    bus.glide_en = 1'b0;

    // reset while three voices sound and two keys wait
    bus.keys = 12'h000;
    step(2);
    bus.keys = 12'h007;
    step(4);
    check("pre_rst_mute", mutes(), 64'h8);
    bus.keys = 12'h067;
    step(1);
    rst = 1'b1;
    bus.keys = 12'h000;
    step(1);
    check("mid_rst_mute", mutes(), 64'hF);
    check("mid_rst_inc_or", 64'(|bus.nco_increment_value), 64'd0);
    check("mid_rst_keys", 64'(bus.voice_key), 64'd0);
    check("mid_rst_led", 64'(bus.test_LED_R), 64'd1);
    check("mid_rst_steal_ptr", 64'(dut.steal_ptr), 64'd0);
    rst = 1'b0;
    step(3);
    check("post_rst_idle", mutes(), 64'hF);
    bus.keys = 12'h200;
    step(2);
    check("post_rst_alloc_mute", mutes(), 64'hE);
    check("post_rst_alloc_inc", inc(0), 64'd39370534);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
